// File: rtl/trap_csr_sequencer.sv
// trap_csr_sequencer: turns exceptions, interrupts and mret into ordered CSR writes plus a PC redirect
// Ports: clk/rst (async, active-high); i_exc_* exception event; i_irq_ext level interrupt;
// i_mret_valid mret retiring; i_mstatus/i_mie live CSRs; i_csr_rdata CSR read data;
// i_p_* pipeline CSR access (passed through when idle); o_csr_* CSR file port;
// o_stall pipeline freeze; o_redirect/o_redirect_pc one-cycle PC redirect.
module trap_csr_sequencer #(
    parameter logic [11:0] A_MSTATUS = 12'h300,
    parameter logic [11:0] A_MTVEC   = 12'h305,
    parameter logic [11:0] A_MEPC    = 12'h341,
    parameter logic [11:0] A_MCAUSE  = 12'h342,
    parameter logic [11:0] A_MTVAL   = 12'h343
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_code,
    input  logic [31:0] i_exc_tval,
    input  logic [31:0] i_exc_pc,
    input  logic        i_irq_ext,
    input  logic        i_mret_valid,
    input  logic [31:0] i_mstatus,
    input  logic [31:0] i_mie,
    input  logic [31:0] i_csr_rdata,
    input  logic [11:0] i_p_raddr,
    input  logic [11:0] i_p_waddr,
    input  logic [31:0] i_p_wdata,
    input  logic        i_p_csr_w,
    input  logic [1:0]  i_p_wsc_mode,
    output logic [11:0] o_csr_raddr,
    output logic [11:0] o_csr_waddr,
    output logic [31:0] o_csr_wdata,
    output logic        o_csr_w,
    output logic [1:0]  o_csr_wsc_mode,
    output logic        o_stall,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc
);
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, JMP_TVEC, R_STAT, JMP_EPC} state_t;
    state_t r_state, w_next;
    logic [31:0] r_pc, r_cause, r_tval;
    logic w_irq, w_trap, w_accept;
    assign w_irq    = i_irq_ext & i_mstatus[3] & i_mie[11];
    assign w_trap   = i_exc_valid | w_irq;
    assign w_accept = (r_state == IDLE) & (w_trap | i_mret_valid);
    always_comb begin
        w_next         = r_state;
        o_csr_raddr    = '0;
        o_csr_waddr    = '0;
        o_csr_wdata    = '0;
        o_csr_w        = 1'b0;
        o_csr_wsc_mode = 2'b01;
        o_stall        = 1'b1;
        o_redirect     = 1'b0;
        o_redirect_pc  = '0;
        case (r_state)
            IDLE: begin
                o_csr_raddr    = i_p_raddr;
                o_csr_waddr    = i_p_waddr;
                o_csr_wdata    = i_p_wdata;
                o_csr_w        = i_p_csr_w & ~w_accept;
                o_csr_wsc_mode = i_p_wsc_mode;
                o_stall        = w_accept;
                w_next         = w_trap ? W_EPC : i_mret_valid ? R_STAT : IDLE;
            end
            W_EPC: begin
                o_csr_waddr = A_MEPC;
                o_csr_wdata = {r_pc[31:2], 2'b00};
                o_csr_w     = 1'b1;
                w_next      = W_CAUSE;
            end
            W_CAUSE: begin
                o_csr_waddr = A_MCAUSE;
                o_csr_wdata = r_cause;
                o_csr_w     = 1'b1;
                w_next      = W_TVAL;
            end
            W_TVAL: begin
                o_csr_waddr = A_MTVAL;
                o_csr_wdata = r_tval;
                o_csr_w     = 1'b1;
                w_next      = W_STAT;
            end
            W_STAT: begin
                // MPIE <= MIE, MIE <= 0
                o_csr_waddr = A_MSTATUS;
                o_csr_wdata = (i_mstatus & ~32'h88) | {24'h0, i_mstatus[3], 7'h0};
                o_csr_w     = 1'b1;
                w_next      = JMP_TVEC;
            end
            JMP_TVEC: begin
                o_csr_raddr   = A_MTVEC;
                o_redirect    = 1'b1;
                o_redirect_pc = {i_csr_rdata[31:2], 2'b00};
                w_next        = IDLE;
            end
            R_STAT: begin
                // MIE <= MPIE, MPIE <= 1
                o_csr_waddr = A_MSTATUS;
                o_csr_wdata = (i_mstatus & ~32'h8) | {28'h0, i_mstatus[7], 3'h0} | 32'h80;
                o_csr_w     = 1'b1;
                w_next      = JMP_EPC;
            end
            JMP_EPC: begin
                o_csr_raddr   = A_MEPC;
                o_redirect    = 1'b1;
                o_redirect_pc = i_csr_rdata;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
            r_tval  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_trap) begin
                r_pc    <= i_exc_pc;
                r_cause <= i_exc_valid ? {28'h0, i_exc_code} : 32'h8000_000B;
                r_tval  <= i_exc_valid ? i_exc_tval : 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_trap_csr_sequencer.sv
// tb_trap_csr_sequencer: directed bench with a queue-based expected-transaction model
module tb_trap_csr_sequencer;
    logic clk, rst, exc_valid, irq_ext, mret_valid, p_csr_w, csr_w, stall, redirect;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval, exc_pc, mstatus, mie, csr_rdata, p_wdata, csr_wdata, redirect_pc;
    logic [11:0] p_raddr, p_waddr, csr_raddr, csr_waddr;
    logic [1:0]  p_wsc_mode, csr_wsc_mode;
    logic [31:0] tvec, mepc;

    trap_csr_sequencer dut (
        .clk(clk), .rst(rst), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
        .i_exc_tval(exc_tval), .i_exc_pc(exc_pc), .i_irq_ext(irq_ext),
        .i_mret_valid(mret_valid), .i_mstatus(mstatus), .i_mie(mie),
        .i_csr_rdata(csr_rdata), .i_p_raddr(p_raddr), .i_p_waddr(p_waddr),
        .i_p_wdata(p_wdata), .i_p_csr_w(p_csr_w), .i_p_wsc_mode(p_wsc_mode),
        .o_csr_raddr(csr_raddr), .o_csr_waddr(csr_waddr), .o_csr_wdata(csr_wdata),
        .o_csr_w(csr_w), .o_csr_wsc_mode(csr_wsc_mode), .o_stall(stall),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // CSR file read side: only mtvec and mepc matter here
    always_comb csr_rdata = csr_raddr == 12'h305 ? tvec : csr_raddr == 12'h341 ? mepc : 32'h0;

    typedef struct {
        logic        w;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        rd;
        logic [11:0] ra;
        logic [31:0] rpc;
    } ent_t;
    ent_t q[$];
    ent_t e;
    logic [43:0] wlog[$];
    int vec = 0, miss = 0, nred = 0;
    logic [31:0] last_rpc;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Expected behaviour: an idle cycle either passes the pipeline through or accepts
    // one event and queues the fixed list of cycles that the event must produce.
    always @(negedge clk) begin
        logic irqt, acc, ew;
        logic [31:0] ms_w;
        if (rst) begin
            q.delete();
            chk("rst_stall", stall, 0);
            chk("rst_redirect", redirect, 0);
            chk("rst_rpc", redirect_pc, 0);
            chk("rst_csr_w", csr_w, p_csr_w);
        end else if (q.size() == 0) begin
            irqt = irq_ext & mstatus[3] & mie[11];
            acc  = exc_valid | irqt | mret_valid;
            ew   = p_csr_w & ~acc;
            chk("idle_stall", stall, acc);
            chk("idle_csr_w", csr_w, ew);
            chk("idle_raddr", csr_raddr, p_raddr);
            chk("idle_redirect", redirect, 0);
            if (ew) begin
                chk("idle_waddr", csr_waddr, p_waddr);
                chk("idle_wdata", csr_wdata, p_wdata);
                chk("idle_mode", csr_wsc_mode, p_wsc_mode);
            end
            if (exc_valid || irqt) begin
                ms_w = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
                q.push_back('{1, 12'h341, exc_pc & ~32'h3, 0, 0, 0});
                q.push_back('{1, 12'h342, exc_valid ? {28'h0, exc_code} : 32'h8000000B, 0, 0, 0});
                q.push_back('{1, 12'h343, exc_valid ? exc_tval : 32'h0, 0, 0, 0});
                q.push_back('{1, 12'h300, ms_w, 0, 0, 0});
                q.push_back('{0, 0, 0, 1, 12'h305, tvec & ~32'h3});
            end else if (mret_valid) begin
                ms_w = (mstatus & ~32'h8) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
                q.push_back('{1, 12'h300, ms_w, 0, 0, 0});
                q.push_back('{0, 0, 0, 1, 12'h341, mepc});
            end
        end else begin
            e = q.pop_front();
            chk("seq_stall", stall, 1);
            chk("seq_csr_w", csr_w, e.w);
            chk("seq_redirect", redirect, e.rd);
            if (e.w) begin
                chk("seq_waddr", csr_waddr, e.wa);
                chk("seq_wdata", csr_wdata, e.wd);
                chk("seq_mode", csr_wsc_mode, 2'b01);
            end
            if (e.rd) begin
                chk("seq_raddr", csr_raddr, e.ra);
                chk("seq_rpc", redirect_pc, e.rpc);
            end
        end
        if (csr_w) wlog.push_back({csr_waddr, csr_wdata});
        if (redirect) begin
            nred++;
            last_rpc = redirect_pc;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_ev;
        exc_valid = 0; irq_ext = 0; mret_valid = 0;
    endtask

    int b, r;
    initial begin
        rst = 1; clr_ev(); exc_code = 0; exc_tval = 0; exc_pc = 0;
        mstatus = 0; mie = 0; p_raddr = 12'h123; p_waddr = 0; p_wdata = 0;
        p_csr_w = 0; p_wsc_mode = 0; tvec = 0; mepc = 0;
        cyc(2);
        rst = 0;
        cyc(1);

        // exception, code 2
        b = wlog.size(); r = nred;
        exc_valid = 1; exc_code = 2; exc_pc = 32'h100; exc_tval = 32'hDEADBEEF;
        mstatus = 32'h88; tvec = 32'h1000;
        cyc(1); clr_ev(); cyc(7);
        chk("s1_nwrites", wlog.size() - b, 4);
        chk("s1_mepc", wlog[b], {12'h341, 32'h100});
        chk("s1_mcause", wlog[b+1], {12'h342, 32'h2});
        chk("s1_mtval", wlog[b+2], {12'h343, 32'hDEADBEEF});
        chk("s1_mstatus", wlog[b+3], {12'h300, 32'h80});
        chk("s1_nred", nred - r, 1);
        chk("s1_rpc", last_rpc, 32'h1000);

        // external interrupt, enabled
        b = wlog.size();
        irq_ext = 1; mie = 32'h800; exc_pc = 32'h204; exc_tval = 32'h55; exc_code = 6;
        cyc(1); clr_ev(); cyc(7);
        chk("s2_mepc", wlog[b], {12'h341, 32'h204});
        chk("s2_mcause", wlog[b+1], {12'h342, 32'h8000000B});
        chk("s2_mtval", wlog[b+2], {12'h343, 32'h0});

        // interrupt masked by MIE=0
        b = wlog.size();
        irq_ext = 1; mstatus = 32'h80;
        cyc(4); clr_ev(); cyc(2);
        chk("s3_nwrites", wlog.size() - b, 0);

        // mret
        b = wlog.size(); r = nred;
        mret_valid = 1; mstatus = 32'h80; mepc = 32'h204;
        cyc(1); clr_ev(); cyc(4);
        chk("s4_mstatus", wlog[b], {12'h300, 32'h88});
        chk("s4_nred", nred - r, 1);
        chk("s4_rpc", last_rpc, 32'h204);

        // exception and mret together, second exception during sequence
        b = wlog.size();
        exc_valid = 1; mret_valid = 1; exc_code = 11; exc_pc = 32'h103; exc_tval = 0;
        mstatus = 32'h8; tvec = 32'h2003;
        cyc(1); clr_ev(); cyc(1);
        exc_valid = 1; exc_code = 4; exc_pc = 32'h400;
        cyc(1); clr_ev(); cyc(6);
        chk("s5_nwrites", wlog.size() - b, 4);
        chk("s5_mepc", wlog[b], {12'h341, 32'h100});
        chk("s5_mcause", wlog[b+1], {12'h342, 32'hB});
        chk("s5_mstatus", wlog[b+3], {12'h300, 32'h80});
        chk("s5_rpc", last_rpc, 32'h2000);

        // reset during W_CAUSE
        b = wlog.size(); r = nred;
        exc_valid = 1; exc_code = 0; exc_pc = 32'h500; exc_tval = 32'h77; mstatus = 32'h88;
        cyc(1); clr_ev(); cyc(1);
        rst = 1;
        #1 chk("s6_stall_now", stall, 0);
        cyc(1); rst = 0; cyc(6);
        chk("s6_nwrites", wlog.size() - b, 1);
        chk("s6_nred", nred - r, 0);

        // pipeline pass-through while idle
        b = wlog.size();
        p_csr_w = 1; p_waddr = 12'h304; p_wdata = 32'h800; p_wsc_mode = 2'b10; p_raddr = 12'h304;
        #1 chk("s7_waddr", csr_waddr, 12'h304);
        chk("s7_mode", csr_wsc_mode, 2'b10);
        chk("s7_w", csr_w, 1);
        cyc(1); p_csr_w = 0; cyc(2);
        chk("s7_nwrites", wlog.size() - b, 1);
        chk("s7_log", wlog[b], {12'h304, 32'h800});

        chk("model_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
